// File: rtl/multicycle_control_if.sv
// Control-unit bundle between the multicycle sequencer (master) and its datapath (slave).
// Carries the decode inputs, the fetch/memory handshakes and the datapath strobes.
interface multicycle_control_if #(
    parameter int OPCODE_W = 4,
    parameter int RETIRE_W = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                imem_ready;
    logic                alu_zero;
    logic                dmem_ready;
    logic                imem_req;
    logic                ir_we;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic [1:0]          alu_op;
    logic                alu_src_imm;
    logic                reg_we;
    logic [1:0]          wb_sel;
    logic                dmem_req;
    logic                dmem_we;
    logic [1:0]          category;
    logic                halted;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  opcode, imem_ready, alu_zero, dmem_ready,
        output imem_req, ir_we, pc_we, pc_src, alu_op, alu_src_imm, reg_we, wb_sel,
               dmem_req, dmem_we, category, halted, illegal, retired
    );

    modport slave (
        output opcode, imem_ready, alu_zero, dmem_ready,
        input  imem_req, ir_we, pc_we, pc_src, alu_op, alu_src_imm, reg_we, wb_sel,
               dmem_req, dmem_we, category, halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU sequencer: FETCH/DECODE/EXEC/MEM/WB/HALTED with a retired-instruction counter.
// Strobes decode from state plus the opcode latched at the end of DECODE.
module multicycle_control #(
    parameter int OPCODE_W        = 4,
    parameter int RETIRE_W        = 16,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(4'b1000);

    logic [2:0]          state_q, state_d;
    logic [OPCODE_W-1:0] opc_q;
    logic                illegal_q;
    logic [RETIRE_W-1:0] retired_q;

    logic [3:0] op4;
    logic       known;
    logic       retire;

    logic       imem_req, ir_we, pc_we, alu_src_imm, reg_we, dmem_req, dmem_we;
    logic [1:0] pc_src, alu_op, wb_sel, category;

    // Any set bit above the low nibble, or a nibble past NOP, is an unknown opcode.
    assign op4   = opc_q[3:0];
    assign known = ((opc_q >> 4) == '0) && (op4 <= 4'd8);

    always_comb begin
        category = 2'b11;
        if (known) begin
            case (op4)
                4'd0, 4'd1, 4'd2: category = 2'b00;
                4'd3, 4'd4:       category = 2'b01;
                4'd5, 4'd7:       category = 2'b10;
                default:          category = 2'b11;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'b00;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (!known) begin
                    if (HALT_ON_ILLEGAL != 0) begin
                        state_d = S_HALTED;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    case (op4)
                        4'd0, 4'd1, 4'd2: begin
                            alu_op      = (op4 == 4'd1) ? 2'b01 : 2'b00;
                            alu_src_imm = (op4 == 4'd2);
                            state_d     = S_WB;
                        end
                        4'd3, 4'd4: begin
                            alu_src_imm = 1'b1;
                            state_d     = S_MEM;
                        end
                        4'd5: begin
                            alu_op  = 2'b01;
                            pc_src  = 2'b01;
                            pc_we   = bus.alu_zero;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        4'd6: begin
                            retire  = 1'b1;
                            state_d = S_HALTED;
                        end
                        4'd7: begin
                            pc_we   = 1'b1;
                            pc_src  = 2'b10;
                            state_d = S_WB;
                        end
                        default: begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op4 == 4'd4);
                if (bus.dmem_ready) begin
                    if (op4 == 4'd3) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (op4 == 4'd3) ? 2'b01 : ((op4 == 4'd7) ? 2'b10 : 2'b00);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opc_q     <= OP_NOP;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) opc_q <= bus.opcode;
            if (state_q == S_EXEC && !known) illegal_q <= 1'b1;
            if (retire) retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    // Reset gates the strobes combinationally so an in-flight access drops at once.
    assign bus.imem_req    = rst_n & imem_req;
    assign bus.ir_we       = rst_n & ir_we;
    assign bus.pc_we       = rst_n & pc_we;
    assign bus.pc_src      = {2{rst_n}} & pc_src;
    assign bus.alu_op      = {2{rst_n}} & alu_op;
    assign bus.alu_src_imm = rst_n & alu_src_imm;
    assign bus.reg_we      = rst_n & reg_we;
    assign bus.wb_sel      = {2{rst_n}} & wb_sel;
    assign bus.dmem_req    = rst_n & dmem_req;
    assign bus.dmem_we     = rst_n & dmem_we;
    assign bus.category    = category;
    assign bus.halted      = rst_n & (state_q == S_HALTED);
    assign bus.illegal     = illegal_q;
    assign bus.retired     = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model, random and directed programs.
// DUT A: default widths, unknown opcode = NOP. DUT B: 6-bit opcode, 4-bit counter, unknown halts.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       alu_zero = 1'b0;
    logic [3:0] op_a = 4'd8;
    logic [5:0] op_b = 6'd8;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_ret  [2];
    bit exp_ill  [2];
    bit exp_halt [2];

    logic       e_imem, e_ir, e_pcwe, e_imm, e_regwe, e_dreq, e_dwe, e_halt;
    logic [1:0] e_pcsrc, e_aluop, e_wbsel;

    multicycle_control_if #(.OPCODE_W(4), .RETIRE_W(16)) ifa ();
    multicycle_control_if #(.OPCODE_W(6), .RETIRE_W(4))  ifb ();

    assign ifa.opcode = op_a;
    assign ifa.imem_ready = imem_ready;
    assign ifa.dmem_ready = dmem_ready;
    assign ifa.alu_zero = alu_zero;
    assign ifb.opcode = op_b;
    assign ifb.imem_ready = imem_ready;
    assign ifb.dmem_ready = dmem_ready;
    assign ifb.alu_zero = alu_zero;

    multicycle_control #(.OPCODE_W(4), .RETIRE_W(16), .HALT_ON_ILLEGAL(0)) u_dut_a (
        .clk(clk), .rst_n(rst_a_n), .bus(ifa.master)
    );
    multicycle_control #(.OPCODE_W(6), .RETIRE_W(4), .HALT_ON_ILLEGAL(1)) u_dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(ifb.master)
    );

    always #5 clk = ~clk;

    logic [13:0] obs_a, obs_b;
    assign obs_a = {ifa.imem_req, ifa.ir_we, ifa.pc_we, ifa.pc_src, ifa.alu_op, ifa.alu_src_imm,
                    ifa.reg_we, ifa.wb_sel, ifa.dmem_req, ifa.dmem_we, ifa.halted};
    assign obs_b = {ifb.imem_req, ifb.ir_we, ifb.pc_we, ifb.pc_src, ifb.alu_op, ifb.alu_src_imm,
                    ifb.reg_we, ifb.wb_sel, ifb.dmem_req, ifb.dmem_we, ifb.halted};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [13:0] exp_vec();
        return {e_imem, e_ir, e_pcwe, e_pcsrc, e_aluop, e_imm, e_regwe, e_wbsel, e_dreq, e_dwe, e_halt};
    endfunction

    task automatic clr_exp();
        {e_imem, e_ir, e_pcwe, e_imm, e_regwe, e_dreq, e_dwe, e_halt} = '0;
        {e_pcsrc, e_aluop, e_wbsel} = '0;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic logic [31:0] get_retired(input int sel);
        return (sel == 0) ? 32'(ifa.retired) : 32'(ifb.retired);
    endfunction

    function automatic logic [31:0] ret_model(input int sel);
        return (sel == 0) ? 32'(exp_ret[0] % 65536) : 32'(exp_ret[1] % 16);
    endfunction

    function automatic logic [1:0] cat_model(input int v);
        if (v <= 2) return 2'b00;
        if (v == 3 || v == 4) return 2'b01;
        if (v == 5 || v == 7) return 2'b10;
        return 2'b11;
    endfunction

    // One clock cycle: drive inputs on the falling edge, then compare the strobe vector.
    task automatic cyc(input int sel, input logic im, input logic dm, input logic [5:0] opv,
                       input string tag);
        @(negedge clk);
        imem_ready = im;
        dmem_ready = dm;
        if (sel == 0) op_a = opv[3:0];
        else op_b = opv;
        #1;
        check($sformatf("%s.%s", (sel == 0) ? "A" : "B", tag),
              32'((sel == 0) ? obs_a : obs_b), 32'(exp_vec()));
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        #2;
        if (sel == 0) rst_a_n = 1'b0;
        else rst_b_n = 1'b0;
        #1;
        check("rst.strobes", 32'((sel == 0) ? obs_a : obs_b), 32'd0);
        check("rst.retired", get_retired(sel), 32'd0);
        check("rst.illegal", 32'((sel == 0) ? ifa.illegal : ifb.illegal), 32'd0);
        check("rst.category", 32'((sel == 0) ? ifa.category : ifb.category), 32'd3);
        exp_ret[sel]  = 0;
        exp_ill[sel]  = 1'b0;
        exp_halt[sel] = 1'b0;
        repeat (2) @(negedge clk);
        imem_ready = 1'b0;
        if (sel == 0) rst_a_n = 1'b1;
        else rst_b_n = 1'b1;
        #1;
        check("rst.release_imem_req", 32'((sel == 0) ? ifa.imem_req : ifb.imem_req), 32'd1);
    endtask

    // Runs one instruction end to end; zsel 0/1 forces alu_zero, 2 randomises it.
    task automatic run_instr(input int sel, input int op, input int fwait, input int mwait,
                             input bit abort, input int zsel);
        bit   unk, hoi, halts;
        logic z;
        hoi = (sel == 1);
        unk = (op > 8);
        z = (zsel == 2) ? rnd() : 1'(zsel);
        alu_zero = z;
        for (int i = 0; i < fwait; i++) begin
            clr_exp(); e_imem = 1'b1;
            cyc(sel, 1'b0, rnd(), rnd6(), "fetch_wait");
        end
        clr_exp(); e_imem = 1'b1; e_ir = 1'b1; e_pcwe = 1'b1;
        cyc(sel, 1'b1, rnd(), rnd6(), "fetch");
        clr_exp();
        cyc(sel, rnd(), rnd(), 6'(op), "decode");
        clr_exp();
        if (!unk) begin
            case (op)
                0, 1, 2: begin e_aluop = (op == 1) ? 2'b01 : 2'b00; e_imm = (op == 2); end
                3, 4:    e_imm = 1'b1;
                5:       begin e_aluop = 2'b01; e_pcsrc = 2'b01; e_pcwe = z; end
                7:       begin e_pcwe = 1'b1; e_pcsrc = 2'b10; end
                default: ;
            endcase
        end
        cyc(sel, rnd(), rnd(), rnd6(), $sformatf("exec.op%0d", op));
        if (unk) exp_ill[sel] = 1'b1;
        if (op == 3 || op == 4) begin
            clr_exp(); e_dreq = 1'b1; e_dwe = (op == 4);
            for (int i = 0; i < mwait; i++) cyc(sel, rnd(), 1'b0, rnd6(), "mem_wait");
            if (abort) return;
            cyc(sel, rnd(), 1'b1, rnd6(), "mem");
        end
        if (op <= 3 || op == 7) begin
            clr_exp(); e_regwe = 1'b1;
            e_wbsel = (op == 3) ? 2'b01 : ((op == 7) ? 2'b10 : 2'b00);
            cyc(sel, rnd(), rnd(), rnd6(), "wb");
        end
        halts = (op == 6) || (unk && hoi);
        if (!(unk && hoi)) exp_ret[sel]++;
        if (halts) exp_halt[sel] = 1'b1;
        @(posedge clk);
        #1;
        check("retired", get_retired(sel), ret_model(sel));
        check("illegal", 32'((sel == 0) ? ifa.illegal : ifb.illegal), 32'(exp_ill[sel]));
        check("category", 32'((sel == 0) ? ifa.category : ifb.category),
              32'(unk ? 2'b11 : cat_model(op)));
        check("halted", 32'((sel == 0) ? ifa.halted : ifb.halted), 32'(exp_halt[sel]));
        if (halts) begin
            for (int i = 0; i < 20; i++) begin
                clr_exp(); e_halt = 1'b1;
                cyc(sel, rnd(), rnd(), rnd6(), "halted_idle");
            end
            check("halted.retired", get_retired(sel), ret_model(sel));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        do_reset(0);
        do_reset(1);

        run_instr(0, 0, 0, 0, 1'b0, 2);
        run_instr(0, 2, 0, 0, 1'b0, 2);
        run_instr(0, 1, 0, 0, 1'b0, 2);
        run_instr(0, 3, 0, 3, 1'b0, 2);
        run_instr(0, 4, 1, 0, 1'b0, 2);
        run_instr(0, 5, 0, 0, 1'b0, 1);
        run_instr(0, 5, 0, 0, 1'b0, 0);
        run_instr(0, 7, 0, 0, 1'b0, 2);
        run_instr(0, 8, 2, 0, 1'b0, 2);
        run_instr(0, 10, 0, 0, 1'b0, 2);

        repeat (40) begin
            op = int'($urandom_range(0, 15));
            if (op == 6) op = 8;
            run_instr(0, op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 2);
        end

        do_reset(0);
        run_instr(0, 3, 0, 5, 1'b1, 2);
        do_reset(0);
        run_instr(0, 6, 0, 0, 1'b0, 2);
        do_reset(0);
        run_instr(0, 0, 0, 0, 1'b0, 2);

        do_reset(1);
        repeat (17) run_instr(1, 8, 0, 0, 1'b0, 2);
        repeat (10) begin
            op = int'($urandom_range(0, 8));
            if (op == 6) op = 8;
            run_instr(1, op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 2);
        end
        run_instr(1, 16, 0, 0, 1'b0, 2);
        do_reset(1);
        run_instr(1, 4, 0, 1, 1'b0, 2);
        run_instr(1, 10, 0, 0, 1'b0, 2);
        do_reset(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, meaning instruction opcode width (>= 4).
REQ-002 SHALL have parameter RETIRE_W, default 16, meaning retired-instruction counter width.
REQ-003 SHALL have parameter HALT_ON_ILLEGAL, default 0, meaning 1 = unknown opcode halts, 0 = unknown opcode treated as NOP.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-005 Port: opcode  in  OPCODE_W  opcode field from instruction register.
REQ-006 Port: imem_ready  in  1  instruction fetch complete; alu_zero  in  1  ALU equality result.
REQ-007 Port: dmem_ready  in  1  data access complete.
REQ-008 Port: imem_req  out  1; ir_we  out  1; pc_we  out  1; pc_src  out  2 (00 pc+1, 01 branch target, 10 jump target).
REQ-009 Port: alu_op  out  2 (00 add, 01 sub); alu_src_imm  out  1; reg_we  out  1; wb_sel  out  2 (00 ALU, 01 memory, 10 link).
REQ-010 Port: dmem_req  out  1; dmem_we  out  1; category  out  2; halted  out  1; illegal  out  1; retired  out  RETIRE_W.

Function
REQ-011 Opcode map (zero-extended to OPCODE_W; any set bit above bit 3 = unknown): ADD 0000, SUB 0001, ADDI 0010, LOAD 0011, STORE 0100, BEQ 0101, HALT 0110, JAL 0111, NOP 1000.
REQ-012 Category SHALL be: ADD/SUB/ADDI 00; LOAD/STORE 01; BEQ/JAL 10; HALT/NOP/unknown 11.
REQ-013 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALTED; outputs are combinational on state plus latched opcode, except where stated otherwise.
REQ-014 FETCH: imem_req=1; on the cycle imem_ready=1, ir_we=1 and pc_we=1 (pc_src=00); next state DECODE; otherwise stay in FETCH.
REQ-015 DECODE: one cycle; opcode and category latched at the end of the cycle; no strobes asserted; next state EXEC.
REQ-016 EXEC, ALU class: alu_op=00 (ADD/ADDI) or 01 (SUB), alu_src_imm=1 for ADDI only; next state WB.
REQ-017 EXEC, LOAD/STORE: alu_op=00, alu_src_imm=1 (address calc); next state MEM.
REQ-018 EXEC, BEQ: alu_op=01, pc_src=01, pc_we=alu_zero; retire; next state FETCH.
REQ-019 EXEC, JAL: pc_we=1, pc_src=10; next state WB.
REQ-020 EXEC, NOP: retire; next state FETCH. HALT: retire; next state HALTED.
REQ-021 EXEC, unknown opcode: illegal set (sticky until reset); HALT_ON_ILLEGAL=0 -> retire and go to FETCH; HALT_ON_ILLEGAL=1 -> go to HALTED without retiring.
REQ-022 MEM: dmem_req=1, dmem_we=1 for STORE only; held until dmem_ready=1; then LOAD -> WB, STORE -> retire and go to FETCH.
REQ-023 WB: reg_we=1 for exactly one cycle; wb_sel=01 for LOAD, 10 for JAL, 00 otherwise; retire; next state FETCH.
REQ-024 HALTED: halted=1, all strobes 0; the block stays in HALTED until reset, ignoring imem_ready and dmem_ready.
REQ-025 Retire: retired increments by 1 on the cycle the instruction completes, wrapping to 0 modulo 2^RETIRE_W.
REQ-026 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-027 Latency, no wait states: ALU/JAL/LOAD 4/4/5 cycles fetch-to-retire; BEQ/NOP/STORE 3/3/4.

Reset
REQ-028 rst_n=0 SHALL immediately force state FETCH, retired=0, illegal=0, halted=0, latched opcode=NOP, and all strobes 0 while asserted.
REQ-029 Reset asserted mid-MEM or mid-FETCH SHALL abort the access; dmem_req and imem_req drop asynchronously.
REQ-030 The first FETCH after reset deassertion SHALL occur on the first rising clk edge with rst_n=1.

Verification
REQ-031 Sequence ADD, ADDI, SUB with imem_ready and dmem_ready tied 1 -> reg_we pulses 3 times; alu_src_imm=1 only for ADDI; retired=3 after 12 cycles.
REQ-032 LOAD with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; WB has wb_sel=01; STORE -> dmem_we=1 and no reg_we.
REQ-033 BEQ with alu_zero=1 -> pc_we with pc_src=01 in EXEC; BEQ with alu_zero=0 -> no pc_we in EXEC; JAL -> pc_src=10, then reg_we with wb_sel=10.
REQ-034 Opcode 1010: with HALT_ON_ILLEGAL=0 -> illegal=1, category=11, fetch continues; with HALT_ON_ILLEGAL=1 -> halted=1 and retired unchanged.
REQ-035 HALT -> halted=1, imem_req stays 0 for 20 cycles; rst_n pulse -> halted=0, retired=0, imem_req=1.
REQ-036 RETIRE_W=4 with 17 NOPs -> retired=1 (wrap); OPCODE_W=6 with opcode 010000 -> treated as unknown.
